alu_result_stage: RTL and testbench

Registered downstream stage for the 32-bit ALU/flag unit: captures each ALU result with its Zero/Overflow/CarryOut flags and destination tag, buffers up to two entries behind a valid/ready handshake, and keeps an architectural NZCV flag register plus a saturating overflow-event counter. It decouples the combinational ALU from the writeback/consumer stage so back-pressure never corrupts an in-flight result.

---
 rtl/alu_result_stage_pkg.sv | 28 ++
 rtl/alu_result_stage_if.sv | 40 ++++
 rtl/alu_result_stage_skid_fifo.sv | 76 +++++++
 rtl/alu_result_stage.sv | 78 +++++++
 tb/tb_alu_result_stage.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared ALU definitions: operand width, ALUop encodings and NZCV flag bit positions.
// Both the combinational ALU and its result stage import this package.
package alu_defs;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] ALUOP_AND = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_ADD = 3'b010;
    localparam logic [2:0] ALUOP_SUB = 3'b110;
    localparam logic [2:0] ALUOP_SLT = 3'b111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Only ADD/SUB produce architecturally meaningful carry and overflow.
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == ALUOP_ADD) || (op == ALUOP_SUB);
    endfunction

    function automatic logic op_is_defined(input logic [2:0] op);
        return (op == ALUOP_AND) || (op == ALUOP_OR) || (op == ALUOP_ADD) ||
               (op == ALUOP_SUB) || (op == ALUOP_SLT);
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Bundle of the ALU-side push port, consumer-side pop port and flag/counter outputs.
// The stage uses the slave modport; the environment driving it uses master.
interface alu_result_stage_if #(
    parameter int DATA_WIDTH = alu_defs::DATA_WIDTH,
    parameter int DEST_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            ALUop;
    logic [DATA_WIDTH-1:0] Result;
    logic                  Overflow;
    logic                  CarryOut;
    logic                  Zero;
    logic [DEST_WIDTH-1:0] Dest;
    logic                  flag_clear;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_Result;
    logic [DEST_WIDTH-1:0] out_Dest;
    logic                  out_Overflow;
    logic                  out_CarryOut;
    logic                  out_Zero;

    logic [3:0]            Flags;
    logic [CNT_WIDTH-1:0]  ovf_count;

    modport slave (
        input  in_valid, ALUop, Result, Overflow, CarryOut, Zero, Dest, flag_clear, out_ready,
        output in_ready, out_valid, out_Result, out_Dest, out_Overflow, out_CarryOut, out_Zero,
        output Flags, ovf_count
    );

    modport master (
        output in_valid, ALUop, Result, Overflow, CarryOut, Zero, Dest, flag_clear, out_ready,
        input  in_ready, out_valid, out_Result, out_Dest, out_Overflow, out_CarryOut, out_Zero,
        input  Flags, ovf_count
    );
endinterface

// File: rtl/alu_result_stage_skid_fifo.sv
// Two-entry valid/ready FIFO with registered in_ready and register-driven outputs.
// Occupancy is kept as an explicit EMPTY/ONE/FULL state.
module alu_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             push;
    logic             pop;

    assign push      = in_valid && in_ready_q;
    assign pop       = (state_q != EMPTY) && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = mem_q[head_q];

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        mem_d   = mem_q;
        case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (push) begin
            mem_d[tail_q] = in_data;
            tail_d        = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        // Registered ready: FULL blocks pushes even when the head leaves this cycle.
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            in_ready_q <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
            mem_q      <= mem_d;
        end
    end
endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the ALU: buffers results in a 2-entry FIFO and
// maintains the NZCV flag register and a saturating overflow-event counter.
module alu_result_stage #(
    parameter int DATA_WIDTH = alu_defs::DATA_WIDTH,
    parameter int DEST_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_result_stage_if.slave   bus
);
    import alu_defs::*;

    localparam int PAYLOAD_W = DATA_WIDTH + DEST_WIDTH + 3;

    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 fifo_in_ready;
    logic                 push;

    logic [3:0]           flags_q, flags_d;
    logic [CNT_WIDTH-1:0] ovf_count_q, ovf_count_d;

    assign in_payload = {bus.Result, bus.Dest, bus.Overflow, bus.CarryOut, bus.Zero};
    assign push       = bus.in_valid && fifo_in_ready;

    alu_skid_fifo #(
        .WIDTH (PAYLOAD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_data   (in_payload),
        .in_ready  (fifo_in_ready),
        .out_valid (bus.out_valid),
        .out_data  (out_payload),
        .out_ready (bus.out_ready)
    );

    assign bus.in_ready = fifo_in_ready;
    assign {bus.out_Result, bus.out_Dest, bus.out_Overflow, bus.out_CarryOut, bus.out_Zero} = out_payload;

    always_comb begin
        flags_d = flags_q;
        // Clear first so a same-cycle push overrides only the fields it writes.
        if (bus.flag_clear) begin
            flags_d = '0;
        end
        if (push && op_is_defined(bus.ALUop)) begin
            flags_d[FLAG_N] = bus.Result[DATA_WIDTH-1];
            flags_d[FLAG_Z] = bus.Zero;
            if (op_is_arith(bus.ALUop)) begin
                flags_d[FLAG_C] = bus.CarryOut;
                flags_d[FLAG_V] = bus.Overflow;
            end
        end
    end

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (push && bus.Overflow && op_is_arith(bus.ALUop) && (ovf_count_q != '1)) begin
            ovf_count_d = ovf_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q     <= '0;
            ovf_count_q <= '0;
        end else begin
            flags_q     <= flags_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign bus.Flags     = flags_q;
    assign bus.ovf_count = ovf_count_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed, table-driven bench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_result_stage_if #(.DATA_WIDTH(32), .DEST_WIDTH(5), .CNT_WIDTH(16)) bus ();

    alu_result_stage #(
        .DATA_WIDTH (32),
        .DEST_WIDTH (5),
        .CNT_WIDTH  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] res;
        logic        ovf;
        logic        cout;
        logic        zero;
        logic [4:0]  dest;
        logic        clr;
        logic [3:0]  exp_flags;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] res, input logic ovf,
                         input logic cout, input logic zero, input logic [4:0] dest);
        bus.ALUop    = op;
        bus.Result   = res;
        bus.Overflow = ovf;
        bus.CarryOut = cout;
        bus.Zero     = zero;
        bus.Dest     = dest;
    endtask

    initial begin
        // op, result, ovf, cout, zero, dest, clear, expected NZCV, expected count
        vecs[0]  = '{OP_ADD, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 5'd4,  1'b0, 4'b1001, 16'd1};
        vecs[1]  = '{OP_SUB, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 4'b0110, 16'd1};
        vecs[2]  = '{OP_AND, 32'hFFFF_0000, 1'b1, 1'b0, 1'b0, 5'd6,  1'b0, 4'b1010, 16'd1};
        vecs[3]  = '{OP_OR,  32'h0000_0000, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 4'b0110, 16'd1};
        vecs[4]  = '{3'b011, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 5'd8,  1'b0, 4'b0110, 16'd1};
        vecs[5]  = '{OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 5'd9,  1'b0, 4'b0011, 16'd2};
        vecs[6]  = '{OP_SLT, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 5'd10, 1'b0, 4'b0011, 16'd2};
        vecs[7]  = '{OP_ADD, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 5'd11, 1'b1, 4'b0000, 16'd2};
        vecs[8]  = '{OP_AND, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 5'd12, 1'b1, 4'b1000, 16'd2};
        vecs[9]  = '{3'b100, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 5'd13, 1'b1, 4'b0000, 16'd2};
        vecs[10] = '{OP_ADD, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd14, 1'b0, 4'b1010, 16'd2};
        vecs[11] = '{OP_SUB, 32'h0000_0010, 1'b1, 1'b1, 1'b0, 5'd15, 1'b0, 4'b0011, 16'd3};
        vecs[12] = '{OP_AND, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 5'd16, 1'b0, 4'b0111, 16'd3};
        vecs[13] = '{OP_OR,  32'h0000_0001, 1'b0, 1'b0, 1'b0, 5'd17, 1'b1, 4'b0000, 16'd3};

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.flag_clear = 1'b0;
        drive(OP_AND, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset Flags", 32'(bus.Flags), 32'd0);
        check("reset ovf_count", 32'(bus.ovf_count), 32'd0);
        check("reset out_Result", bus.out_Result, 32'd0);
        $display("reset: out_valid=%0b in_ready=%0b Flags=%b ovf_count=%0d",
                 bus.out_valid, bus.in_ready, bus.Flags, bus.ovf_count);

        // Table: one push per cycle with the consumer always ready; each entry is head one cycle later.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op, vecs[i].res, vecs[i].ovf, vecs[i].cout, vecs[i].zero, vecs[i].dest);
            bus.flag_clear = vecs[i].clr;
            bus.in_valid   = 1'b1;
            check("vec in_ready", 32'(bus.in_ready), 32'd1);
            @(negedge clk);
            check("vec out_valid", 32'(bus.out_valid), 32'd1);
            check("vec out_Result", bus.out_Result, vecs[i].res);
            check("vec out_Dest", 32'(bus.out_Dest), 32'(vecs[i].dest));
            check("vec out_flags", 32'({bus.out_Overflow, bus.out_CarryOut, bus.out_Zero}),
                  32'({vecs[i].ovf, vecs[i].cout, vecs[i].zero}));
            check("vec Flags", 32'(bus.Flags), 32'(vecs[i].exp_flags));
            check("vec ovf_count", 32'(bus.ovf_count), 32'(vecs[i].exp_cnt));
            $display("vec %0d: op=%b res=0x%08h dest=%0d clr=%0b -> Flags=%b ovf_count=%0d",
                     i, vecs[i].op, bus.out_Result, bus.out_Dest, vecs[i].clr, bus.Flags, bus.ovf_count);
        end
        bus.in_valid   = 1'b0;
        bus.flag_clear = 1'b0;
        @(negedge clk);
        check("drain out_valid", 32'(bus.out_valid), 32'd0);

        // Back-pressure: three SUBs with the consumer stalled, then released.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(OP_SUB, 32'h1, 1'b0, 1'b1, 1'b0, 5'd1);
        @(negedge clk);
        check("bp in_ready after 1", 32'(bus.in_ready), 32'd1);
        check("bp head after 1", 32'(bus.out_Dest), 32'd1);
        drive(OP_SUB, 32'h2, 1'b0, 1'b1, 1'b0, 5'd2);
        @(negedge clk);
        check("bp in_ready after 2", 32'(bus.in_ready), 32'd0);
        check("bp out_valid full", 32'(bus.out_valid), 32'd1);
        check("bp head full", 32'(bus.out_Dest), 32'd1);
        drive(OP_SUB, 32'h3, 1'b0, 1'b1, 1'b0, 5'd3);
        @(negedge clk);
        check("bp in_ready held", 32'(bus.in_ready), 32'd0);
        check("bp head held", 32'(bus.out_Dest), 32'd1);
        $display("backpressure: full, head dest=%0d, dest 3 held", bus.out_Dest);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp deliver 2", 32'(bus.out_Dest), 32'd2);
        check("bp in_ready reopen", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check("bp deliver 3", 32'(bus.out_Dest), 32'd3);
        check("bp deliver 3 valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp no duplicate", 32'(bus.out_valid), 32'd0);
        $display("backpressure: delivered 1,2,3 in order");

        // Sustained throughput: push and pop every cycle in the ONE state.
        bus.in_valid = 1'b1;
        for (int j = 0; j < 11; j++) begin
            drive(OP_OR, 32'(j), 1'b0, 1'b0, 1'b0, 5'(j + 8));
            @(negedge clk);
            check("stream out_valid", 32'(bus.out_valid), 32'd1);
            check("stream in_ready", 32'(bus.in_ready), 32'd1);
            check("stream out_Dest", 32'(bus.out_Dest), 32'(j + 8));
            $display("stream %0d: dest=%0d in_ready=%0b", j, bus.out_Dest, bus.in_ready);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Reset while FULL discards buffered entries and clears state.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(OP_ADD, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 5'd30);
        repeat (2) @(negedge clk);
        check("pre-reset full", 32'(bus.in_ready), 32'd0);
        check("pre-reset ovf_count", 32'(bus.ovf_count), 32'd5);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        check("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset in_ready", 32'(bus.in_ready), 32'd1);
        check("midreset Flags", 32'(bus.Flags), 32'd0);
        check("midreset ovf_count", 32'(bus.ovf_count), 32'd0);
        check("midreset out_Result", bus.out_Result, 32'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midreset no ghost", 32'(bus.out_valid), 32'd0);
        end
        $display("reset while full: out_valid=%0b in_ready=%0b Flags=%b ovf_count=%0d",
                 bus.out_valid, bus.in_ready, bus.Flags, bus.ovf_count);

        // Counter saturation.
        bus.in_valid = 1'b1;
        drive(OP_ADD, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 5'd1);
        repeat (65534) @(negedge clk);
        check("sat 0xFFFE", 32'(bus.ovf_count), 32'h0000_FFFE);
        @(negedge clk);
        check("sat 0xFFFF", 32'(bus.ovf_count), 32'h0000_FFFF);
        @(negedge clk);
        check("sat hold", 32'(bus.ovf_count), 32'h0000_FFFF);
        drive(OP_SLT, 32'h1, 1'b1, 1'b0, 1'b0, 5'd2);
        @(negedge clk);
        check("sat slt", 32'(bus.ovf_count), 32'h0000_FFFF);
        bus.in_valid = 1'b0;
        $display("saturation: ovf_count=0x%04h", bus.ovf_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
